// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, opcodes and FSM states for the calculator key sequencer
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_ENTER = 4'd14;
  localparam logic [3:0] KEY_ESC   = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    SHOW     = 3'd4
  } state_t;

  function automatic opcode_t key_to_opcode(input logic [3:0] code);
    case (code)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// rtl/calc_key_sequencer_if.sv - request/result bus between key sequencer and arithmetic stage
interface calc_key_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [WIDTH-1:0] OP_A;
  logic [WIDTH-1:0] OP_B;
  logic [1:0]       OPCODE;
  logic             RES_VALID;
  logic [WIDTH-1:0] RES_DATA;
  logic             RES_ERR;

  modport master (
    output REQ_VALID, OP_A, OP_B, OPCODE,
    input  REQ_READY, RES_VALID, RES_DATA, RES_ERR
  );

  modport slave (
    input  REQ_VALID, OP_A, OP_B, OPCODE,
    output REQ_READY, RES_VALID, RES_DATA, RES_ERR
  );
endinterface

// File: rtl/dec_accum.sv
// rtl/dec_accum.sv - value*10 + digit with overflow detection, purely combinational
module dec_accum #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  localparam int W4 = WIDTH + 4;

  logic [W4-1:0] wide;

  // Four guard bits hold the worst case (2^WIDTH-1)*10+9 without wrapping.
  assign wide   = ({4'b0, value} << 3) + ({4'b0, value} << 1) + W4'(digit);
  assign result = wide[WIDTH-1:0];
  assign ovf    = |wide[W4-1:WIDTH];
endmodule

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - assembles key codes into operand/operator requests and captures results
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 KEY_VALID,
  input  logic [3:0]           KEY_CODE,
  calc_key_sequencer_if.master bus,
  output logic [WIDTH-1:0]     DISP_VALUE,
  output logic                 ERR,
  output logic                 OVF,
  output logic [2:0]           STATE
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] op_a_q, op_a_n;
  logic [WIDTH-1:0] op_b_q, op_b_n;
  opcode_t          opcode_q, opcode_n;
  logic             err_q, err_n;
  logic             ovf_q, ovf_n;
  logic             b_digits_q, b_digits_n;
  logic             discard_q, discard_n;
  logic [WIDTH-1:0] disp_q, disp_n;
  logic             res_taken;

  logic             is_digit, is_op;
  logic [WIDTH-1:0] acc_in, acc_out;
  logic             acc_ovf;

  assign is_digit = (KEY_CODE <= 4'd9);
  assign is_op    = (KEY_CODE >= KEY_ADD) && (KEY_CODE <= KEY_DIV);
  assign acc_in   = (state_q == ENTER_B) ? op_b_q : op_a_q;

  dec_accum #(.WIDTH(WIDTH)) u_accum (
    .value  (acc_in),
    .digit  (KEY_CODE),
    .result (acc_out),
    .ovf    (acc_ovf)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ENTER_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= OP_ADD;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      b_digits_q <= 1'b0;
      discard_q  <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_n;
      op_a_q     <= op_a_n;
      op_b_q     <= op_b_n;
      opcode_q   <= opcode_n;
      err_q      <= err_n;
      ovf_q      <= ovf_n;
      b_digits_q <= b_digits_n;
      discard_q  <= discard_n;
      disp_q     <= disp_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    op_a_n     = op_a_q;
    op_b_n     = op_b_q;
    opcode_n   = opcode_q;
    err_n      = err_q;
    ovf_n      = 1'b0;
    b_digits_n = b_digits_q;
    discard_n  = discard_q;
    res_taken  = 1'b0;

    // A result that arrives after an Escape belongs to an abandoned request.
    if (bus.RES_VALID && discard_q) begin
      discard_n = 1'b0;
    end else if (bus.RES_VALID && state_q == WAIT_RES) begin
      op_a_n    = bus.RES_DATA;
      err_n     = bus.RES_ERR;
      state_n   = SHOW;
      res_taken = 1'b1;
    end

    if (state_q == ISSUE) begin
      if (bus.REQ_READY) begin
        state_n   = WAIT_RES;
        discard_n = 1'b0;
      end
    end else if (KEY_VALID && !res_taken) begin
      if (KEY_CODE == KEY_ESC) begin
        op_a_n     = '0;
        op_b_n     = '0;
        opcode_n   = OP_ADD;
        err_n      = 1'b0;
        b_digits_n = 1'b0;
        state_n    = ENTER_A;
        if (state_q == WAIT_RES) discard_n = 1'b1;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (is_digit) begin
              if (acc_ovf) ovf_n = 1'b1;
              else         op_a_n = acc_out;
            end else if (is_op) begin
              opcode_n   = key_to_opcode(KEY_CODE);
              op_b_n     = '0;
              b_digits_n = 1'b0;
              state_n    = ENTER_B;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              b_digits_n = 1'b1;
              if (acc_ovf) ovf_n = 1'b1;
              else         op_b_n = acc_out;
            end else if (is_op) begin
              if (!b_digits_q) opcode_n = key_to_opcode(KEY_CODE);
            end else if (KEY_CODE == KEY_ENTER && b_digits_q) begin
              state_n = ISSUE;
            end
          end
          SHOW: begin
            if (!err_q && is_digit) begin
              op_a_n  = WIDTH'(KEY_CODE);
              state_n = ENTER_A;
            end else if (!err_q && is_op) begin
              opcode_n   = key_to_opcode(KEY_CODE);
              op_b_n     = '0;
              b_digits_n = 1'b0;
              state_n    = ENTER_B;
            end
          end
          default: ;
        endcase
      end
    end

    // Display follows the post-edge values so it never lags the state.
    case (state_n)
      ENTER_B:         disp_n = b_digits_n ? op_b_n : op_a_n;
      ISSUE, WAIT_RES: disp_n = op_b_n;
      default:         disp_n = op_a_n;
    endcase
  end

  always_comb begin
    bus.REQ_VALID = (state_q == ISSUE);
    bus.OP_A      = op_a_q;
    bus.OP_B      = op_b_q;
    bus.OPCODE    = opcode_q;
    DISP_VALUE    = disp_q;
    ERR           = err_q;
    OVF           = ovf_q;
    STATE         = state_q;
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - scoreboard bench for calc_key_sequencer
module tb_calc_key_sequencer;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } req_t;

  logic        CLK;
  logic        RST_N;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic [15:0] DISP_VALUE;
  logic        ERR;
  logic        OVF;
  logic [2:0]  STATE;

  req_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  calc_key_sequencer_if #(.WIDTH(16)) bus ();

  calc_key_sequencer #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .KEY_VALID  (KEY_VALID),
    .KEY_CODE   (KEY_CODE),
    .bus        (bus),
    .DISP_VALUE (DISP_VALUE),
    .ERR        (ERR),
    .OVF        (OVF),
    .STATE      (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every cycle a request is presented it must match the oldest expectation.
  always @(negedge CLK) begin
    if (RST_N && bus.REQ_VALID) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got a=%0d b=%0d op=%0d expected none",
                 bus.OP_A, bus.OP_B, bus.OPCODE);
      end else begin
        check("req_ops", {bus.OP_A, bus.OP_B, bus.OPCODE},
              {exp_q[0].a, exp_q[0].b, exp_q[0].op});
        if (bus.REQ_READY) void'(exp_q.pop_front());
      end
    end
  end

  task automatic press(input logic [3:0] code);
    @(posedge CLK); #1;
    KEY_VALID = 1'b1;
    KEY_CODE  = code;
    @(posedge CLK); #1;
    KEY_VALID = 1'b0;
  endtask

  task automatic result(input logic [15:0] data, input logic err);
    @(posedge CLK); #1;
    bus.RES_VALID = 1'b1;
    bus.RES_DATA  = data;
    bus.RES_ERR   = err;
    @(posedge CLK); #1;
    bus.RES_VALID = 1'b0;
  endtask

  task automatic expect_req(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    exp_q.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N         = 1'b0;
    KEY_VALID     = 1'b0;
    KEY_CODE      = 4'd0;
    bus.REQ_READY = 1'b0;
    bus.RES_VALID = 1'b0;
    bus.RES_DATA  = 16'd0;
    bus.RES_ERR   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_state", STATE, 0);
    check("rst_disp", DISP_VALUE, 0);
    check("rst_err", ERR, 0);
    check("rst_ovf", OVF, 0);
    check("rst_req_valid", bus.REQ_VALID, 0);
    check("rst_op_a", bus.OP_A, 0);
    RST_N = 1'b1;

    // 12 + 34 with a stalled handshake
    press(4'd1); press(4'd2);
    check("a_12", bus.OP_A, 12);
    check("disp_a_12", DISP_VALUE, 12);
    press(4'd10);
    check("state_enter_b", STATE, 1);
    check("disp_before_b", DISP_VALUE, 12);
    press(4'd3); press(4'd4);
    check("disp_b_34", DISP_VALUE, 34);
    expect_req(16'd12, 16'd34, 2'd0);
    press(4'd14);
    check("state_issue", STATE, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_valid", bus.REQ_VALID, 1);
    end
    @(posedge CLK); #1;
    bus.REQ_READY = 1'b1;
    @(posedge CLK); #1;
    bus.REQ_READY = 1'b0;
    check("state_wait", STATE, 3);
    check("valid_dropped", bus.REQ_VALID, 0);
    result(16'd46, 1'b0);
    check("state_show", STATE, 4);
    check("disp_46", DISP_VALUE, 46);

    // chain 46 - 6 with ready already high on entry to ISSUE
    press(4'd11);
    check("chain_state", STATE, 1);
    check("chain_disp", DISP_VALUE, 46);
    press(4'd6);
    expect_req(16'd46, 16'd6, 2'd1);
    bus.REQ_READY = 1'b1;
    press(4'd14);
    @(posedge CLK); #1;
    bus.REQ_READY = 1'b0;
    check("chain_wait", STATE, 3);
    result(16'd40, 1'b0);
    press(4'd7);
    check("show_digit_a", bus.OP_A, 7);
    check("show_digit_state", STATE, 0);
    check("show_digit_disp", DISP_VALUE, 7);

    // overflow boundary at 65535
    press(4'd15);
    press(4'd6); press(4'd5); press(4'd5); press(4'd3); press(4'd5);
    check("a_max", bus.OP_A, 65535);
    press(4'd6);
    check("ovf_pulse", OVF, 1);
    check("a_kept", bus.OP_A, 65535);
    @(posedge CLK); #1;
    check("ovf_clear", OVF, 0);

    // divide by zero -> sticky error, only Escape accepted
    press(4'd13);
    check("opcode_div", bus.OPCODE, 3);
    press(4'd0);
    expect_req(16'd65535, 16'd0, 2'd3);
    bus.REQ_READY = 1'b1;
    press(4'd14);
    @(posedge CLK); #1;
    bus.REQ_READY = 1'b0;
    result(16'd0, 1'b1);
    check("err_set", ERR, 1);
    press(4'd5); press(4'd10); press(4'd14);
    check("err_state_held", STATE, 4);
    check("err_a_held", bus.OP_A, 0);
    check("err_sticky", ERR, 1);
    press(4'd15);
    check("esc_err", ERR, 0);
    check("esc_state", STATE, 0);
    check("esc_disp", DISP_VALUE, 0);

    // operator replacement, then Escape in WAIT_RES discards the result
    press(4'd9); press(4'd12); press(4'd11);
    check("op_replaced", bus.OPCODE, 1);
    press(4'd2); press(4'd10);
    check("op_locked", bus.OPCODE, 1);
    expect_req(16'd9, 16'd2, 2'd1);
    bus.REQ_READY = 1'b1;
    press(4'd14);
    @(posedge CLK); #1;
    bus.REQ_READY = 1'b0;
    press(4'd15);
    check("wait_esc_state", STATE, 0);
    result(16'd99, 1'b0);
    check("discard_a", bus.OP_A, 0);
    check("discard_state", STATE, 0);
    check("discard_disp", DISP_VALUE, 0);

    // reset in the middle of ISSUE
    press(4'd3); press(4'd10); press(4'd4);
    expect_req(16'd3, 16'd4, 2'd0);
    press(4'd14);
    check("issue2_state", STATE, 2);
    #3;
    RST_N = 1'b0;
    #1;
    check("async_req_valid", bus.REQ_VALID, 0);
    check("async_state", STATE, 0);
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;

    // Enter with no B digit must not issue
    press(4'd5); press(4'd10);
    bus.REQ_READY = 1'b1;
    press(4'd14);
    repeat (2) @(posedge CLK);
    #1;
    bus.REQ_READY = 1'b0;
    check("no_b_state", STATE, 1);
    check("no_b_valid", bus.REQ_VALID, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
